// File: rtl/rv32_csr_unit_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, SYSTEM opcode,
// Zicsr funct3 codes and the ecall cause value.
package rv32_csr_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CSR_WIDTH  = 12;

  localparam logic [CSR_WIDTH-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_WIDTH-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_WIDTH-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_WIDTH-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_WIDTH-1:0] CSR_MCAUSE   = 12'h342;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [DATA_WIDTH-1:0] MCAUSE_ECALL_M = 32'd11;

  // funct3[1:0] selects the operation; funct3[2] only picks the operand source.
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

endpackage

// File: rtl/rv32_csr_wdata_calc.sv
// Combinational Zicsr new-value calculation: computes the value to commit and
// whether the op writes at all (set/clear with a zero rs1/uimm field do not).
module rv32_csr_wdata_calc (
  input  logic [2:0]  funct3,
  input  logic [31:0] old_val,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rs1_field,
  output logic        we,
  output logic [31:0] new_val
);
  import rv32_csr_unit_pkg::*;

  logic unused_funct3;
  assign unused_funct3 = funct3[2];

  always_comb begin
    we      = 1'b0;
    new_val = old_val;
    case (csr_op_e'(funct3[1:0]))
      CSR_OP_RW: begin
        we      = 1'b1;
        new_val = wr_data;
      end
      CSR_OP_RS: begin
        we      = (rs1_field != 5'd0);
        new_val = old_val | wr_data;
      end
      CSR_OP_RC: begin
        we      = (rs1_field != 5'd0);
        new_val = old_val & ~wr_data;
      end
      default: begin
        we      = 1'b0;
        new_val = old_val;
      end
    endcase
  end

endmodule

// File: rtl/rv32_csr_unit.sv
// Machine-mode CSR file (mstatus, mtvec, mepc, mcause) with Zicsr RMW and ecall/mret
// bookkeeping. Define CSR_MSCRATCH_EN to add mscratch at 0x340.
module rv32_csr_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    CSR_WIDTH   = 12,
  parameter logic [DATA_WIDTH-1:0] MSTATUS_RST = 32'h0000_1800,
  parameter logic [DATA_WIDTH-1:0] MTVEC_RST   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CSR_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [CSR_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  i_csr_ecall,
  input  logic                  i_csr_mret,
  input  logic [31:0]           i_inst,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic [DATA_WIDTH-1:0] o_mstatus,
  output logic [DATA_WIDTH-1:0] o_mtvec,
  output logic [DATA_WIDTH-1:0] o_mpec
);
  import rv32_csr_unit_pkg::*;

  logic [DATA_WIDTH-1:0] mstatus_q;
  logic [DATA_WIDTH-1:0] mtvec_q;
  logic [DATA_WIDTH-1:0] mepc_q;
  logic [DATA_WIDTH-1:0] mcause_q;
`ifdef CSR_MSCRATCH_EN
  logic [DATA_WIDTH-1:0] mscratch_q;
`endif

  logic [DATA_WIDTH-1:0] old_val;
  logic [DATA_WIDTH-1:0] new_val;
  logic                  calc_we;
  logic                  csr_op_valid;
  logic                  csr_wr;

  logic unused_inst;
  assign unused_inst = ^{i_inst[31:20], i_inst[11:7]};

  // Read port and the RMW "old" operand share the same address map.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CSR_MSTATUS:  rd_data = mstatus_q;
      CSR_MTVEC:    rd_data = mtvec_q;
      CSR_MEPC:     rd_data = mepc_q;
      CSR_MCAUSE:   rd_data = mcause_q;
`ifdef CSR_MSCRATCH_EN
      CSR_MSCRATCH: rd_data = mscratch_q;
`endif
      default:      rd_data = '0;
    endcase
  end

  always_comb begin
    old_val = '0;
    case (wr_addr)
      CSR_MSTATUS:  old_val = mstatus_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
`ifdef CSR_MSCRATCH_EN
      CSR_MSCRATCH: old_val = mscratch_q;
`endif
      default:      old_val = '0;
    endcase
  end

  assign csr_op_valid = (i_inst[6:0] == OPC_SYSTEM) && (i_inst[13:12] != 2'b00);

  rv32_csr_wdata_calc u_wdata_calc (
    .funct3    (i_inst[14:12]),
    .old_val   (old_val),
    .wr_data   (wr_data),
    .rs1_field (i_inst[19:15]),
    .we        (calc_we),
    .new_val   (new_val)
  );

  // ecall and mret both pre-empt any CSR write in the same cycle.
  assign csr_wr = csr_op_valid && calc_we && !i_csr_ecall && !i_csr_mret;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_RST;
      mtvec_q    <= MTVEC_RST;
      mepc_q     <= '0;
      mcause_q   <= '0;
`ifdef CSR_MSCRATCH_EN
      mscratch_q <= '0;
`endif
    end else if (i_csr_ecall) begin
      mepc_q   <= i_pc;
      mcause_q <= MCAUSE_ECALL_M;
    end else if (csr_wr) begin
      case (wr_addr)
        CSR_MSTATUS:  mstatus_q  <= new_val;
        CSR_MTVEC:    mtvec_q    <= new_val;
        CSR_MEPC:     mepc_q     <= new_val;
        CSR_MCAUSE:   mcause_q   <= new_val;
`ifdef CSR_MSCRATCH_EN
        CSR_MSCRATCH: mscratch_q <= new_val;
`endif
        default: ;
      endcase
    end
  end

  assign o_mstatus = mstatus_q;
  assign o_mtvec   = mtvec_q;
  assign o_mpec    = mepc_q;

endmodule

// File: tb/tb_rv32_csr_unit.sv
// Self-checking bench for rv32_csr_unit: directed scenarios plus randomized traffic
// checked against an address-keyed reference model of the CSR file.
module tb_rv32_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        i_csr_ecall;
  logic        i_csr_mret;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [31:0] o_mstatus;
  logic [31:0] o_mtvec;
  logic [31:0] o_mpec;

  int n_pass  = 0;
  int n_total = 0;

  // Model: implemented CSRs exist as keys; anything absent reads 0 and ignores writes.
  logic [31:0] model [int unsigned];

  rv32_csr_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .i_csr_ecall (i_csr_ecall),
    .i_csr_mret  (i_csr_mret),
    .i_inst      (i_inst),
    .i_pc        (i_pc),
    .o_mstatus   (o_mstatus),
    .o_mtvec     (o_mtvec),
    .o_mpec      (o_mpec)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    model.delete();
    model[32'h300] = 32'h0000_1800;
    model[32'h305] = 32'h0;
    model[32'h341] = 32'h0;
    model[32'h342] = 32'h0;
`ifdef CSR_MSCRATCH_EN
    model[32'h340] = 32'h0;
`endif
  endtask

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    int unsigned k;
    k = a;
    if (model.exists(k)) return model[k];
    return 32'h0;
  endfunction

  task automatic model_step();
    int unsigned k;
    logic [4:0]  rs1;
    logic [1:0]  op;
    k   = wr_addr;
    rs1 = i_inst[19:15];
    op  = i_inst[13:12];
    if (!rst_n) model_reset();
    else if (i_csr_ecall) begin
      model[32'h341] = i_pc;
      model[32'h342] = 32'd11;
    end else if (i_csr_mret) begin
    end else if (i_inst[6:0] == 7'h73 && op != 2'b00 && model.exists(k)) begin
      if (op == 2'b01) model[k] = wr_data;
      else if (op == 2'b10 && rs1 != 0) model[k] = model[k] | wr_data;
      else if (op == 2'b11 && rs1 != 0) model[k] = model[k] & ~wr_data;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] csr_inst(input logic [11:0] csr, input logic [4:0] rs1,
                                           input logic [2:0] f3);
    return {csr, rs1, f3, 5'd1, 7'h73};
  endfunction

  task automatic set_idle();
    rst_n       = 1'b1;
    i_csr_ecall = 1'b0;
    i_csr_mret  = 1'b0;
    i_inst      = 32'h0000_0013;
    wr_addr     = 12'h0;
    wr_data     = 32'h0;
    rd_addr     = 12'h0;
    i_pc        = 32'h0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n   = 1'b0;
    rd_addr = 12'h342;
    cycle();
    rst_n = 1'b1;
    n_total++; if (o_mstatus !== 32'h1800) $display("FAIL reset_mstatus got=%h exp=%h", o_mstatus, 32'h1800); else n_pass++;
    n_total++; if (o_mtvec !== 32'h0) $display("FAIL reset_mtvec got=%h exp=%h", o_mtvec, 32'h0); else n_pass++;
    n_total++; if (o_mpec !== 32'h0) $display("FAIL reset_mepc got=%h exp=%h", o_mpec, 32'h0); else n_pass++;
    n_total++; if (rd_data !== 32'h0) $display("FAIL reset_mcause got=%h exp=%h", rd_data, 32'h0); else n_pass++;
  endtask

  task automatic test_csrrw_mtvec();
    set_idle();
    i_inst  = 32'h3052_9073;
    wr_addr = 12'h305;
    wr_data = 32'h8000_0100;
    rd_addr = 12'h305;
    #1;
    n_total++; if (rd_data !== 32'h0) $display("FAIL rw_mtvec_old got=%h exp=%h", rd_data, 32'h0); else n_pass++;
    cycle();
    n_total++; if (o_mtvec !== 32'h8000_0100) $display("FAIL rw_mtvec_new got=%h exp=%h", o_mtvec, 32'h8000_0100); else n_pass++;
    n_total++; if (rd_data !== 32'h8000_0100) $display("FAIL rw_mtvec_rd got=%h exp=%h", rd_data, 32'h8000_0100); else n_pass++;
  endtask

  task automatic test_set_clear();
    set_idle();
    wr_addr = 12'h300;
    rd_addr = 12'h300;
    i_inst  = csr_inst(12'h300, 5'd1, 3'b010);
    wr_data = 32'h8;
    cycle();
    n_total++; if (o_mstatus !== 32'h1808) $display("FAIL rs_mstatus got=%h exp=%h", o_mstatus, 32'h1808); else n_pass++;
    i_inst  = csr_inst(12'h300, 5'd2, 3'b011);
    wr_data = 32'h1000;
    cycle();
    n_total++; if (o_mstatus !== 32'h0808) $display("FAIL rc_mstatus got=%h exp=%h", o_mstatus, 32'h0808); else n_pass++;
    i_inst  = csr_inst(12'h300, 5'd0, 3'b010);
    wr_data = 32'hFFFF_FFFF;
    cycle();
    n_total++; if (o_mstatus !== 32'h0808) $display("FAIL rs_x0_mstatus got=%h exp=%h", o_mstatus, 32'h0808); else n_pass++;
    i_inst  = csr_inst(12'h300, 5'd0, 3'b111);
    cycle();
    n_total++; if (o_mstatus !== 32'h0808) $display("FAIL rci_zero_mstatus got=%h exp=%h", o_mstatus, 32'h0808); else n_pass++;
  endtask

  task automatic test_ecall();
    set_idle();
    i_inst      = 32'h0000_0073;
    i_csr_ecall = 1'b1;
    i_pc        = 32'h8000_0040;
    rd_addr     = 12'h342;
    cycle();
    i_csr_ecall = 1'b0;
    n_total++; if (o_mpec !== 32'h8000_0040) $display("FAIL ecall_mepc got=%h exp=%h", o_mpec, 32'h8000_0040); else n_pass++;
    n_total++; if (rd_data !== 32'd11) $display("FAIL ecall_mcause got=%h exp=%h", rd_data, 32'd11); else n_pass++;
    n_total++; if (o_mstatus !== 32'h0808) $display("FAIL ecall_mstatus got=%h exp=%h", o_mstatus, 32'h0808); else n_pass++;
  endtask

  task automatic test_mret_unimpl();
    logic [31:0] exp_scratch;
    set_idle();
    i_inst     = 32'h3020_0073;
    i_csr_mret = 1'b1;
    cycle();
    n_total++; if (o_mpec !== 32'h8000_0040) $display("FAIL mret_mepc got=%h exp=%h", o_mpec, 32'h8000_0040); else n_pass++;
    n_total++; if (o_mstatus !== 32'h0808) $display("FAIL mret_mstatus got=%h exp=%h", o_mstatus, 32'h0808); else n_pass++;
    i_inst  = csr_inst(12'h305, 5'd3, 3'b001);
    wr_addr = 12'h305;
    wr_data = 32'h0;
    cycle();
    i_csr_mret = 1'b0;
    n_total++; if (o_mtvec !== 32'h8000_0100) $display("FAIL mret_over_write got=%h exp=%h", o_mtvec, 32'h8000_0100); else n_pass++;
    i_inst  = csr_inst(12'h7C0, 5'd3, 3'b001);
    wr_addr = 12'h7C0;
    wr_data = 32'hFFFF_FFFF;
    rd_addr = 12'h7C0;
    cycle();
    n_total++; if (rd_data !== 32'h0) $display("FAIL unimpl_read got=%h exp=%h", rd_data, 32'h0); else n_pass++;
    i_inst  = csr_inst(12'h340, 5'd3, 3'b001);
    wr_addr = 12'h340;
    rd_addr = 12'h340;
    cycle();
`ifdef CSR_MSCRATCH_EN
    exp_scratch = 32'hFFFF_FFFF;
`else
    exp_scratch = 32'h0;
`endif
    n_total++; if (rd_data !== exp_scratch) $display("FAIL mscratch_read got=%h exp=%h", rd_data, exp_scratch); else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_idle();
    rst_n   = 1'b0;
    i_inst  = csr_inst(12'h341, 5'd1, 3'b001);
    wr_addr = 12'h341;
    wr_data = 32'h1234;
    cycle();
    rst_n = 1'b1;
    n_total++; if (o_mpec !== 32'h0) $display("FAIL rst_mid_mepc got=%h exp=%h", o_mpec, 32'h0); else n_pass++;
    n_total++; if (o_mstatus !== 32'h1800) $display("FAIL rst_mid_mstatus got=%h exp=%h", o_mstatus, 32'h1800); else n_pass++;
    n_total++; if (o_mtvec !== 32'h0) $display("FAIL rst_mid_mtvec got=%h exp=%h", o_mtvec, 32'h0); else n_pass++;
  endtask

  function automatic logic [11:0] pick_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h340;
      3: return 12'h341;
      4: return 12'h342;
      5: return 12'h7C0;
      default: return r[11:0];
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] hi;
    logic [4:0]  rs1;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic [31:0] exp;
    for (int i = 0; i < 400; i++) begin
      set_idle();
      hi      = $urandom;
      rs1     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      f3      = 3'($urandom_range(0, 7));
      opc     = ($urandom_range(0, 9) < 8) ? 7'h73 : 7'h33;
      wr_addr = pick_addr();
      rd_addr = pick_addr();
      i_inst  = {hi[31:20], rs1, f3, hi[11:7], opc};
      wr_data = $urandom;
      i_pc    = $urandom;
      i_csr_ecall = ($urandom_range(0, 19) == 0);
      i_csr_mret  = ($urandom_range(0, 19) == 0);
      rst_n       = ($urandom_range(0, 39) != 0);
      #1;
      exp = ref_read(rd_addr);
      n_total++; if (rd_data !== exp) $display("FAIL rand_rd[%0d] addr=%h got=%h exp=%h", i, rd_addr, rd_data, exp); else n_pass++;
      cycle();
      exp = ref_read(12'h300);
      n_total++; if (o_mstatus !== exp) $display("FAIL rand_mstatus[%0d] got=%h exp=%h", i, o_mstatus, exp); else n_pass++;
      exp = ref_read(12'h305);
      n_total++; if (o_mtvec !== exp) $display("FAIL rand_mtvec[%0d] got=%h exp=%h", i, o_mtvec, exp); else n_pass++;
      exp = ref_read(12'h341);
      n_total++; if (o_mpec !== exp) $display("FAIL rand_mepc[%0d] got=%h exp=%h", i, o_mpec, exp); else n_pass++;
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_csrrw_mtvec();
    test_set_clear();
    test_ecall();
    test_mret_unimpl();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
